div_signed_seq: RTL and testbench



---
 rtl/div_signed_seq_pkg.sv | 18 +
 rtl/div_restore_step.sv | 47 ++++
 rtl/div_signed_seq.sv | 146 ++++++++++++++
 tb/tb_div_signed_seq.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/div_signed_seq_pkg.sv
// Shared definitions for the sequential signed divider: FSM state encoding,
// default operand width and the most-negative operand constant.
package div_signed_seq_pkg;

   // Default operand/result width
   localparam int DEF_WIDTH = 8;

   // Most-negative two's-complement value at the default width
   localparam logic [DEF_WIDTH-1:0] MOST_NEG = DEF_WIDTH'(1) << (DEF_WIDTH - 1);

   // Controller states (2-bit encoding)
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2
   } state_t;

endpackage : div_signed_seq_pkg

// File: rtl/div_restore_step.sv
// One restoring-division iteration, purely combinational.
// The partial remainder is shifted left and the next dividend bit is brought
// in. The divisor magnitude is then subtracted as a + ~b + 1 through a
// generate/propagate adder. A carry out means the trial is non-negative,
// so the trial is kept and the quotient bit is 1.
module div_restore_step
   import div_signed_seq_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic [WIDTH:0]   i_rem,    // partial remainder before the step
   input  logic [WIDTH-1:0] i_dvs,    // divisor magnitude
   input  logic             i_bit,    // next dividend-magnitude bit
   output logic [WIDTH:0]   o_rem,    // partial remainder after the step
   output logic             o_q_bit   // quotient bit produced by the step
);

   logic [WIDTH:0] w_shift;
   logic [WIDTH:0] w_b;
   logic [WIDTH:0] w_g;
   logic [WIDTH:0] w_p;
   logic [WIDTH:0] w_sum;
   logic           w_cout;

   // The top remainder bit is shifted out of the adder window. If it was set,
   // the shifted value already exceeds any divisor, so the step must succeed.
   assign w_shift = {i_rem[WIDTH-1:0], i_bit};
   assign w_b     = ~{1'b0, i_dvs};
   assign w_g     = w_shift & w_b;
   assign w_p     = w_shift ^ w_b;

   // Carry chain of the subtractor with carry-in 1 (two's-complement subtract)
   always_comb begin
      logic v_c;
      v_c   = 1'b1;
      w_sum = '0;
      for (int i = 0; i <= WIDTH; i++) begin
         w_sum[i] = w_p[i] ^ v_c;
         v_c      = w_g[i] | (w_p[i] & v_c);
      end
      w_cout = v_c;
   end

   assign o_q_bit = i_rem[WIDTH] | w_cout;
   assign o_rem   = o_q_bit ? w_sum : w_shift;

endmodule : div_restore_step

// File: rtl/div_signed_seq.sv
// Sequential signed two's-complement divider with a start/busy/done handshake.
// The operands are captured as magnitudes, and one restoring iteration runs
// per clock. A final FIX cycle applies the signs: the quotient is truncated
// toward zero and the remainder takes the sign of the dividend.
// Handshake: start is sampled only while idle (busy=0). A start seen while
// busy is dropped. done pulses for one cycle with the results, and the
// results and flags hold until the next done.
module div_signed_seq
   import div_signed_seq_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero,
   output logic             overflow
);

   localparam int                CW         = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0]     L_CNT_ONE  = CW'(1);
   localparam logic [CW-1:0]     L_CNT_LAST = CW'(WIDTH - 1);
   localparam logic [WIDTH-1:0]  L_MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   state_t           r_state;
   state_t           w_state_next;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH:0]   r_rem;
   logic [WIDTH-1:0] r_quo;        // dividend magnitude shifts out, quotient shifts in
   logic [WIDTH-1:0] r_dvs;
   logic             r_sign_q;
   logic             r_sign_r;
   logic             r_dbz_n;
   logic             r_ovf_n;
   logic [WIDTH-1:0] r_quotient;
   logic [WIDTH-1:0] r_remainder;
   logic             r_done;
   logic             r_dbz;
   logic             r_ovf;

   logic [WIDTH-1:0] w_dvd_mag;
   logic [WIDTH-1:0] w_dvs_mag;
   logic [WIDTH:0]   w_rem_step;
   logic             w_q_bit;
   logic [WIDTH-1:0] w_quo_fix;
   logic [WIDTH-1:0] w_rem_fix;

   // Magnitudes. Negating the most-negative value gives 2^(WIDTH-1), which is
   // the correct unsigned magnitude.
   assign w_dvd_mag = dividend[WIDTH-1] ? -dividend : dividend;
   assign w_dvs_mag = divisor[WIDTH-1]  ? -divisor  : divisor;

   div_restore_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .i_rem   (r_rem),
      .i_dvs   (r_dvs),
      .i_bit   (r_quo[WIDTH-1]),
      .o_rem   (w_rem_step),
      .o_q_bit (w_q_bit)
   );

   // A zero divisor yields an all-ones magnitude, which must not be
   // sign-corrected. The remainder comes out equal to the dividend naturally.
   assign w_quo_fix = r_dbz_n  ? '1 : (r_sign_q ? -r_quo : r_quo);
   assign w_rem_fix = r_sign_r ? -r_rem[WIDTH-1:0] : r_rem[WIDTH-1:0];

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_next;
   end

   // Next-state logic
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:    if (start) w_state_next = CALC;
         CALC:    if (r_cnt == L_CNT_LAST) w_state_next = FIX;
         FIX:     w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   // Datapath: capture, iterate, sign-fix and register the results
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt       <= '0;
         r_rem       <= '0;
         r_quo       <= '0;
         r_dvs       <= '0;
         r_sign_q    <= 1'b0;
         r_sign_r    <= 1'b0;
         r_dbz_n     <= 1'b0;
         r_ovf_n     <= 1'b0;
         r_quotient  <= '0;
         r_remainder <= '0;
         r_done      <= 1'b0;
         r_dbz       <= 1'b0;
         r_ovf       <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_sign_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                  r_sign_r <= dividend[WIDTH-1];
                  r_quo    <= w_dvd_mag;
                  r_dvs    <= w_dvs_mag;
                  r_rem    <= '0;
                  r_dbz_n  <= (divisor == '0);
                  r_ovf_n  <= (dividend == L_MOST_NEG) && (divisor == '1);
                  r_cnt    <= '0;
               end
            end
            CALC: begin
               r_rem <= w_rem_step;
               r_quo <= {r_quo[WIDTH-2:0], w_q_bit};
               r_cnt <= r_cnt + L_CNT_ONE;
            end
            FIX: begin
               r_quotient  <= w_quo_fix;
               r_remainder <= w_rem_fix;
               r_dbz       <= r_dbz_n;
               r_ovf       <= r_ovf_n;
               r_done      <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign busy        = (r_state != IDLE);
   assign done        = r_done;
   assign quotient    = r_quotient;
   assign remainder   = r_remainder;
   assign div_by_zero = r_dbz;
   assign overflow    = r_ovf;

endmodule : div_signed_seq

// File: tb/tb_div_signed_seq.sv
// Directed bench for div_signed_seq at WIDTH=8. The expected results are
// computed by hand, and a short random sweep is checked against the signed
// / and % operators.
module tb_div_signed_seq;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [7:0] dividend;
   logic [7:0] divisor;
   logic       busy;
   logic       done;
   logic [7:0] quotient;
   logic [7:0] remainder;
   logic       div_by_zero;
   logic       overflow;

   int n_checks = 0;
   int n_miss   = 0;

   div_signed_seq #(.WIDTH(8)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero),
      .overflow    (overflow)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_miss++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Launch one operation and wait (bounded) for done. Sampling is #1 after
   // each rising edge. lat counts edges from the accepting edge (1) to done.
   task automatic do_op(input logic [7:0] a, input logic [7:0] b,
                        output int lat, output int busy_cyc, output logic d0);
      @(negedge clk);
      start    = 1'b1;
      dividend = a;
      divisor  = b;
      @(posedge clk);
      #1;
      start    = 1'b0;
      dividend = 8'hXX;
      divisor  = 8'hXX;
      lat      = 1;
      busy_cyc = busy ? 1 : 0;
      d0       = done;
      while (!done && lat < 30) begin
         @(posedge clk);
         #1;
         lat++;
         if (busy) busy_cyc++;
      end
   endtask

   task automatic check_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] eq, input logic [7:0] er,
                           input logic edbz, input logic eovf);
      int   lat;
      int   bc;
      logic d0;
      do_op(a, b, lat, bc, d0);
      check({tag, ".done"},    done,        1);
      check({tag, ".latency"}, lat,         10);
      check({tag, ".quot"},    quotient,    eq);
      check({tag, ".rem"},     remainder,   er);
      check({tag, ".dbz"},     div_by_zero, edbz);
      check({tag, ".ovf"},     overflow,    eovf);
   endtask

   initial begin
      int   lat;
      int   bc;
      int   n_done;
      logic d0;
      logic [7:0] q_seen;
      logic [7:0] r_seen;
      logic signed [7:0] ra;
      logic signed [7:0] rb;
      logic signed [7:0] rq;
      logic signed [7:0] rr;

      // Reset
      rst_n    = 1'b0;
      start    = 1'b0;
      dividend = 8'h00;
      divisor  = 8'h00;
      #12;
      check("rst.busy", busy,        0);
      check("rst.done", done,        0);
      check("rst.quot", quotient,    0);
      check("rst.rem",  remainder,   0);
      check("rst.dbz",  div_by_zero, 0);
      check("rst.ovf",  overflow,    0);
      @(negedge clk);
      rst_n = 1'b1;

      // 100/7: latency, busy length, single-cycle done
      do_op(8'd100, 8'd7, lat, bc, d0);
      check("p7.done",    done,      1);
      check("p7.latency", lat,       10);
      check("p7.busy",    bc,        9);
      check("p7.quot",    quotient,  8'h0E);
      check("p7.rem",     remainder, 8'h02);
      check("p7.dbz",     div_by_zero, 0);
      check("p7.ovf",     overflow,  0);
      @(posedge clk);
      #1;
      check("p7.done_pulse", done,     0);
      check("p7.hold_quot",  quotient, 8'h0E);

      // Sign combinations
      check_op("m100_7",  8'h9C, 8'h07, 8'hF2, 8'hFE, 0, 0);
      check_op("100_m7",  8'h64, 8'hF9, 8'hF2, 8'h02, 0, 0);
      check_op("m100_m7", 8'h9C, 8'hF9, 8'h0E, 8'hFE, 0, 0);

      // Most-negative cases
      check_op("ovf",      8'h80, 8'hFF, 8'h80, 8'h00, 0, 1);
      check_op("mneg_1",   8'h80, 8'h01, 8'h80, 8'h00, 0, 0);
      check_op("mneg_mn",  8'h80, 8'h80, 8'h01, 8'h00, 0, 0);
      check_op("127_mneg", 8'h7F, 8'h80, 8'h00, 8'h7F, 0, 0);
      check_op("7_100",    8'h07, 8'h64, 8'h00, 8'h07, 0, 0);

      // Divide by zero, then flags clear on a valid result
      check_op("dbz_5",  8'h05, 8'h00, 8'hFF, 8'h05, 1, 0);
      check_op("dbz_m5", 8'hFB, 8'h00, 8'hFF, 8'hFB, 1, 0);
      check_op("clr",    8'd50, 8'd3,  8'h10, 8'h02, 0, 0);

      // Starts while busy are ignored
      @(negedge clk);
      start    = 1'b1;
      dividend = 8'd100;
      divisor  = 8'd7;
      @(posedge clk);
      #1;
      n_done = 0;
      q_seen = 8'h00;
      r_seen = 8'h00;
      for (int c = 1; c <= 16; c++) begin
         @(negedge clk);
         start    = (c == 3 || c == 7);
         dividend = 8'd50;
         divisor  = 8'd3;
         @(posedge clk);
         #1;
         if (done) begin
            n_done++;
            q_seen = quotient;
            r_seen = remainder;
         end
      end
      start = 1'b0;
      check("ign.n_done", n_done, 1);
      check("ign.quot",   q_seen, 8'h0E);
      check("ign.rem",    r_seen, 8'h02);

      // Start held in the done cycle is accepted back-to-back
      do_op(8'd100, 8'd7, lat, bc, d0);
      check("b2b.first_done", done, 1);
      do_op(8'd50, 8'd3, lat, bc, d0);
      check("b2b.done_fall", d0,        0);
      check("b2b.done",      done,      1);
      check("b2b.latency",   lat,       10);
      check("b2b.quot",      quotient,  8'h10);
      check("b2b.rem",       remainder, 8'h02);

      // Asynchronous reset mid-operation
      @(negedge clk);
      start    = 1'b1;
      dividend = 8'd100;
      divisor  = 8'd7;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst.busy", busy,        0);
      check("arst.done", done,        0);
      check("arst.quot", quotient,    0);
      check("arst.rem",  remainder,   0);
      check("arst.dbz",  div_by_zero, 0);
      check("arst.ovf",  overflow,    0);
      @(negedge clk);
      rst_n  = 1'b1;
      n_done = 0;
      for (int c = 0; c < 15; c++) begin
         @(posedge clk);
         #1;
         if (done) n_done++;
      end
      check("arst.no_done", n_done, 0);
      check_op("arst.fresh", 8'h9C, 8'h07, 8'hF2, 8'hFE, 0, 0);

      // Random sweep against the language's signed divide
      for (int k = 0; k < 300; k++) begin
         ra = 8'($urandom_range(0, 255));
         rb = 8'($urandom_range(0, 255));
         if (rb == 0) rb = 8'sd3;
         if (ra == -8'sd128 && rb == -8'sd1) rb = 8'sd2;
         rq = ra / rb;
         rr = ra % rb;
         check_op("rand", ra, rb, rq, rr, 0, 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_miss);
      $finish;
   end

endmodule : tb_div_signed_seq
